// File: rtl/ode_fixed_pkg.sv
// Shared Q8.7 constants and the step-FSM state encoding for the Euler step datapath.
package ode_fixed_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 7;

  localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
  localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } step_state_e;

endpackage

// File: rtl/fixed_point_add_saturate.sv
// Combinational signed add that clamps to the most positive / most negative code
// instead of wrapping; saturated flags that the clamp was applied.
module fixed_point_add_saturate #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         saturated
);

  logic [W:0] full;

  assign full = {a[W-1], a} + {b[W-1], b};

  // The two top bits of the sign-extended sum disagree exactly when the result
  // does not fit in W bits; the top bit gives the true sign of the result.
  always_comb begin
    saturated = full[W] ^ full[W-1];
    sum       = full[W-1:0];
    if (saturated) begin
      sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ode_step_accumulator.sv
// Euler update stage: x <= sat(x + h*f) for numSteps products, each new state
// emitted on a one-deep valid/ready output register, with a run-wide sticky overflow.
module ode_step_accumulator #(
  parameter int WIDTH = ode_fixed_pkg::WIDTH,
  parameter int FRAC  = ode_fixed_pkg::FRAC,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [CNT_W-1:0] numSteps,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] product,
  input  logic             productOverflow,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outState,
  output logic             done,
  output logic             overflow
);

  import ode_fixed_pkg::*;

  if (FRAC >= WIDTH) begin : g_frac_check
    $error("FRAC must leave room for a sign bit");
  end

  step_state_e      state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] out_state_q, out_state_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_steps_q, num_steps_d;

  logic [WIDTH-1:0] sat_sum;
  logic             sat_flag;
  logic             in_fire, out_fire;

  fixed_point_add_saturate #(.W(WIDTH)) u_add (
    .a         (x_q),
    .b         (product),
    .sum       (sat_sum),
    .saturated (sat_flag)
  );

  // A new product may only enter when the output slot is free or draining now.
  assign inReady  = (state_q == RUN) && (!out_valid_q || outReady);
  assign in_fire  = inValid && inReady;
  assign out_fire = out_valid_q && outReady;

  assign outValid = out_valid_q;
  assign outState = out_state_q;
  assign overflow = overflow_q;
  assign done     = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    num_steps_d = num_steps_q;
    overflow_d  = overflow_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d         = x0;
          cnt_d       = '0;
          num_steps_d = numSteps;
          overflow_d  = 1'b0;
          state_d     = (numSteps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          x_d        = sat_sum;
          cnt_d      = cnt_q + CNT_W'(1);
          overflow_d = overflow_q | productOverflow | sat_flag;
          if (cnt_d == num_steps_q) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_fire) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A simultaneous input fire overwrites the slot, so valid stays asserted.
    if (in_fire) begin
      out_state_d = sat_sum;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      cnt_q       <= '0;
      num_steps_q <= '0;
      overflow_q  <= 1'b0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      num_steps_q <= num_steps_d;
      overflow_q  <= overflow_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ode_step_accumulator.sv
// Directed bench for ode_step_accumulator: hand-computed Q8.7 vectors covering
// nominal run, saturation, backpressure, zero-length runs, ignored start and reset.
module tb_ode_step_accumulator;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] x0;
  logic [CNT_W-1:0] numSteps;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] product;
  logic             productOverflow;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outState;
  logic             done;
  logic             overflow;

  int n_vec;
  int n_err;

  ode_step_accumulator #(.WIDTH(WIDTH), .FRAC(7), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .x0              (x0),
    .numSteps        (numSteps),
    .inValid         (inValid),
    .inReady         (inReady),
    .product         (product),
    .productOverflow (productOverflow),
    .outValid        (outValid),
    .outReady        (outReady),
    .outState        (outState),
    .done            (done),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [15:0] st);
    chk({tag, "_vld"}, {31'b0, outValid}, {31'b0, vld});
    chk({tag, "_state"}, {16'b0, outState}, {16'b0, st});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; x0 = '0; numSteps = '0;
    inValid = 1'b0; product = '0; productOverflow = 1'b0; outReady = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 16'h0000);
    chk("reset_inReady", {31'b0, inReady}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_ovf", {31'b0, overflow}, 32'd0);

    // Nominal run: 2.0 + 0.5 three times
    x0 = 16'h0100; numSteps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nom_inReady", {31'b0, inReady}, 32'd1);
    inValid = 1'b1; product = 16'h0040;
    tick(); chk_out("nom1", 1'b1, 16'h0140);
    tick(); chk_out("nom2", 1'b1, 16'h0180);
    tick(); chk_out("nom3", 1'b1, 16'h01C0);
    inValid = 1'b0;
    #1;
    chk("nom_flush_inReady", {31'b0, inReady}, 32'd0);
    chk("nom_done_early", {31'b0, done}, 32'd0);
    tick();
    chk("nom_done", {31'b0, done}, 32'd1);
    chk_out("nom_final", 1'b0, 16'h01C0);
    chk("nom_ovf", {31'b0, overflow}, 32'd0);

    // Positive saturation, then back inside range with sticky flag
    x0 = 16'h7F00; numSteps = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    inValid = 1'b1; product = 16'h0200;
    tick(); chk_out("psat1", 1'b1, ode_fixed_pkg::Q_MAX);
    chk("psat1_ovf", {31'b0, overflow}, 32'd1);
    product = 16'hFF80;
    tick(); chk_out("psat2", 1'b1, 16'h7F7F);
    chk("psat2_ovf", {31'b0, overflow}, 32'd1);
    inValid = 1'b0;
    tick(); chk("psat_done", {31'b0, done}, 32'd1);

    // Negative saturation; start from DONE also clears overflow
    x0 = 16'h8100; numSteps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nsat_ovf_clr", {31'b0, overflow}, 32'd0);
    inValid = 1'b1; product = 16'hFE00;
    tick(); chk_out("nsat", 1'b1, ode_fixed_pkg::Q_MIN);
    chk("nsat_ovf", {31'b0, overflow}, 32'd1);
    inValid = 1'b0;
    tick(); chk("nsat_done", {31'b0, done}, 32'd1);

    // Multiplier overflow flag on an in-range sum
    x0 = 16'h0100; numSteps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("povf_clr", {31'b0, overflow}, 32'd0);
    inValid = 1'b1; product = 16'h0040; productOverflow = 1'b1;
    tick(); chk_out("povf", 1'b1, 16'h0140);
    chk("povf_ovf", {31'b0, overflow}, 32'd1);
    inValid = 1'b0; productOverflow = 1'b0;
    tick(); chk("povf_done", {31'b0, done}, 32'd1);

    // Backpressure: three stalled cycles after the first output
    x0 = 16'h0000; numSteps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    inValid = 1'b1; product = 16'h0010;
    tick(); chk_out("bp1", 1'b1, 16'h0010);
    outReady = 1'b0; product = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_inReady", {31'b0, inReady}, 32'd0);
      tick();
      chk_out("bp_stall", 1'b1, 16'h0010);
    end
    outReady = 1'b1;
    #1;
    chk("bp_resume_inReady", {31'b0, inReady}, 32'd1);
    tick(); chk_out("bp2", 1'b1, 16'h0030);
    product = 16'h0030;
    tick(); chk_out("bp3", 1'b1, 16'h0060);
    inValid = 1'b0;
    tick(); chk("bp_done", {31'b0, done}, 32'd1);
    chk_out("bp_final", 1'b0, 16'h0060);

    // Zero-length run
    x0 = 16'h1234; numSteps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_vld", {31'b0, outValid}, 32'd0);
    chk("zero_inReady", {31'b0, inReady}, 32'd0);

    // start pulsed mid-run is ignored
    x0 = 16'h0100; numSteps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    inValid = 1'b1; product = 16'h0040;
    tick(); chk_out("mid1", 1'b1, 16'h0140);
    start = 1'b1; x0 = 16'h7000; numSteps = 16'd1;
    tick(); chk_out("mid2", 1'b1, 16'h0180);
    chk("mid2_done", {31'b0, done}, 32'd0);
    start = 1'b0;
    tick(); chk_out("mid3", 1'b1, 16'h01C0);
    inValid = 1'b0;
    tick(); chk("mid_done", {31'b0, done}, 32'd1);

    // Reset after two of five steps
    x0 = 16'h0200; numSteps = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    inValid = 1'b1; product = 16'h0040; productOverflow = 1'b1;
    tick(); chk_out("rr1", 1'b1, 16'h0240);
    productOverflow = 1'b0;
    tick(); chk_out("rr2", 1'b1, 16'h0280);
    rst = 1'b1;
    tick();
    chk_out("rr_reset", 1'b0, 16'h0000);
    chk("rr_inReady", {31'b0, inReady}, 32'd0);
    chk("rr_done", {31'b0, done}, 32'd0);
    chk("rr_ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0; inValid = 1'b0;
    x0 = 16'h0300; numSteps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    inValid = 1'b1;
    tick(); chk_out("rr_fresh", 1'b1, 16'h0340);
    chk("rr_fresh_ovf", {31'b0, overflow}, 32'd0);
    inValid = 1'b0;
    tick(); chk("rr_fresh_done", {31'b0, done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ode_step_accumulator.md
# ode_step_accumulator

Sequential Euler-update stage that sits directly downstream of the Q8.7 fixed-point multiplier in the Step datapath. It consumes the stream of step products `h*f` together with their overflow flags and maintains the state `x_{n+1} = sat(x_n + h*f_n)` over a programmed number of steps. Each updated state is emitted on a valid/ready output. A sticky overflow flag covers the whole run.

## Interface
Parameters:
- `WIDTH`, 16, data width (signed two's complement).
- `FRAC`, 7, fractional bits (Q8.7). The accumulator is format-agnostic; this value is only carried for the package constants.
- `CNT_W`, 16, width of the step counter and of `numSteps`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that loads `x0` and `numSteps`.
- `x0`  in  WIDTH  initial state, signed Q8.7.
- `numSteps`  in  CNT_W  number of updates in the run (unsigned).
- `inValid`  in  1  `product` and `productOverflow` are valid.
- `inReady`  out  1  block accepts a product this cycle.
- `product`  in  WIDTH  `h*f` from the multiplier, signed Q8.7.
- `productOverflow`  in  1  multiplier overflow for this product.
- `outValid`  out  1  `outState` holds an updated state.
- `outReady`  in  1  downstream accepts `outState`.
- `outState`  out  WIDTH  updated state `x_{n+1}`.
- `done`  out  1  level; high in DONE.
- `overflow`  out  1  sticky overflow for the current run.

## Operation
- **States**
  - IDLE: wait for `start`.
  - RUN: accept `numSteps` products.
  - FLUSH: wait for the last output to be accepted.
  - DONE: run complete; `start` is accepted again.
- **`start` in IDLE or DONE**
  - `x <= x0`, `cnt <= 0`, `overflow <= 0`, `done <= 0`.
  - Next state is RUN. If `numSteps == 0`, go straight to DONE with no outputs.
- **`start` in RUN or FLUSH** is ignored.
- **`inReady`** = (state == RUN) && (!outValid || outReady).
- **Input fire** (`inValid && inReady`):
  - Form the (WIDTH+1)-bit sum `x + product`.
  - Saturate to `0x7FFF` / `0x8000`; no wrap-around ever.
  - `x <= sat`, `outState <= sat`, `outValid <= 1`, `cnt <= cnt+1`.
  - `overflow <= overflow | productOverflow | saturated`.
  - If `cnt == numSteps-1`, go to FLUSH.
- **Output fire** (`outValid && outReady`) with no simultaneous input fire: `outValid <= 0`.
- **Input and output fire in the same cycle**: the new value replaces the old one and `outValid` stays 1.
- **FLUSH**: go to DONE on the cycle the last output fires.
- **DONE**: `done` = 1. `outState` keeps the final state while `outValid` = 0.

## Timing
- Reset values: IDLE; `outValid`=0, `outState`=0, `inReady`=0, `done`=0, `overflow`=0, `x`=0, `cnt`=0.
- `rst` asserted mid-run aborts on the same edge. Products in flight are dropped; no partial output.
- `start` to `inReady` high: 1 cycle.
- Input fire to `outValid`: 1 cycle.
- Throughput: 1 product per cycle while `outReady` is held high.
- `done` rises 1 cycle after the final output handshake.
- `outState` and `outValid` are held stable while `outValid && !outReady`.
- `productOverflow` is sampled only on input fire.

## Structure
- **Package `ode_fixed_pkg`** holds:
  - `WIDTH`, `FRAC`, `Q_MAX` = `16'h7FFF`, `Q_MIN` = `16'h8000`;
  - the step-FSM state enum `{IDLE, RUN, FLUSH, DONE}`.
- **Sub-module `fixed_point_add_saturate`**: combinational. Inputs: `a`, `b`. Outputs: `sum`, `saturated`. The top level holds the FSM, the counter and the output register.

## Test plan
- **Nominal run:** `x0`=`0x0100` (2.0), `numSteps`=3, products `0x0040` ×3 with `outReady`=1 → `outState` = `0x0140`, `0x0180`, `0x01C0` on consecutive cycles; `done`=1 one cycle after the last handshake; `overflow`=0.
- **Positive saturation:** `x0`=`0x7F00`, product `0x0200` → `outState`=`0x7FFF`, `overflow`=1. A following product `0xFF80` gives `0x7F7F` and `overflow` stays 1.
- **Negative saturation and multiplier flag:**
  - `x0`=`0x8100`, product `0xFE00` → `0x8000`, `overflow`=1.
  - Separate run with `productOverflow`=1 on an in-range product → `overflow`=1 with the sum unsaturated.
- **Backpressure:** hold `outReady`=0 for 3 cycles after the first output → `inReady`=0 and `outState` stable for those cycles; the sequence resumes with no product lost or duplicated.
- **`numSteps`=0 and `start` mid-run:**
  - `numSteps`=0 → DONE 1 cycle after `start`, no `outValid`.
  - `start` pulsed during RUN → ignored; count and state unchanged.
- **Reset mid-run:** `rst` after 2 of 5 steps → every output at its reset value next cycle; a fresh `start` runs correctly from the new `x0`.
